mem_arbiter: RTL

- Two-requester arbiter that shares the single-port program/data memory between the processor core and the host/debug loader.
- Replaces ad-hoc override muxing with a registered req/ack handshake, host-priority arbitration with CPU anti-starvation, and a host lock for halted-core loading.
- Sits between core, host interface and the memory instance.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / host) arbiter in front of the single-port program/data memory.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int HOST_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_rnw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              mem_rq,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_cpu_stalls
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [7:0] BURST_MAX = 8'(HOST_BURST);

  logic [1:0]        stateQ;
  logic              ownerHost;
  logic              rnwQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [7:0]        burstCnt;

  logic hostWins;
  logic cpuWins;
  logic cpuEligible;

  // Host has priority until it has taken HOST_BURST grants in a row over a waiting CPU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hostWins    = 1'b0;
    cpuWins     = 1'b0;
    cpuEligible = cpu_req && !host_lock;
    if (host_req && !(cpuEligible && burstCnt == BURST_MAX)) begin
      hostWins = 1'b1;
    end else if (cpuEligible) begin
      cpuWins = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      // NOTE: payload registers are reset too so mem_* and rdata are defined from the first cycle.
      stateQ    <= IDLE;
      ownerHost <= 1'b0;
      rnwQ      <= 1'b1;
      addrQ     <= '0;
      wdataQ    <= '0;
      burstCnt  <= '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (!cpu_req) begin
            burstCnt <= '0;
          end
          if (hostWins) begin
            ownerHost <= 1'b1;
            rnwQ      <= host_rnw;
            addrQ     <= host_addr;
            wdataQ    <= host_wdata;
            stateQ    <= ACCESS;
            if (cpu_req && burstCnt != BURST_MAX) begin
              burstCnt <= burstCnt + 8'd1;
            end
          end else if (cpuWins) begin
            ownerHost <= 1'b0;
            rnwQ      <= cpu_rnw;
            addrQ     <= cpu_addr;
            wdataQ    <= cpu_wdata;
            burstCnt  <= '0;
            stateQ    <= ACCESS;
          end
        end
        ACCESS:  stateQ <= RESP;
        RESP:    stateQ <= IDLE;
        default: stateQ <= IDLE;
      endcase
    end
  end

  logic respValid;

  assign mem_rq    = (stateQ == ACCESS);
  assign mem_rnw   = mem_rq ? rnwQ : 1'b1;
  assign mem_addr  = mem_rq ? addrQ : '0;
  assign mem_wdata = (mem_rq && !rnwQ) ? wdataQ : '0;

  // Memory output is already registered, so read data is forwarded during RESP.
  assign respValid  = (stateQ == RESP);
  assign cpu_ack    = respValid && !ownerHost;
  assign host_ack   = respValid && ownerHost;
  assign cpu_rdata  = (cpu_ack && rnwQ) ? mem_rdata : '0;
  assign host_rdata = (host_ack && rnwQ) ? mem_rdata : '0;
  assign busy       = (stateQ != IDLE);

`ifdef MEM_ARB_STATS_EN
  logic cpuInService;

  assign cpuInService = (stateQ == ACCESS || stateQ == RESP) && !ownerHost;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts  <= '0;
      stat_cpu_stalls <= '0;
    end else begin
      if (stateQ == IDLE && cpu_req && host_req && !host_lock && stat_conflicts != 16'hFFFF) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
      if (cpu_req && !cpuInService && stat_cpu_stalls != 16'hFFFF) begin
        stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
      end
    end
  end
`endif

endmodule
